clause_load_ctrl: RTL

CLAUSE_LOAD_CTRL -- requirements
Module: clause_load_ctrl

---
 rtl/clause_load_ctrl_if.sv | 69 ++++++
 rtl/clause_load_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/clause_load_ctrl_if.sv
// Bundle of start pulses, load/unload streams, clause-array access and status
// shared between the clause load controller and its surroundings.
interface clause_load_ctrl_if #(
  parameter int NUM_VARS    = 8,
  parameter int NUM_CLAUSES = 8,
  parameter int WIDTH_C_LEN = 4
);
  localparam int CW    = NUM_VARS * 2;
  localparam int CNT_W = $clog2(NUM_CLAUSES + 1);

  // Pass control
  logic                               load_start_i;
  logic                               unload_start_i;

  // Load stream
  logic                               load_valid_i;
  logic [CW-1:0]                      load_clause_i;
  logic [WIDTH_C_LEN-1:0]             load_len_i;
  logic                               load_last_i;
  logic                               load_ready_o;

  // Clause array write side
  logic [NUM_CLAUSES-1:0]             wr_o;
  logic [CW-1:0]                      clause_o;
  logic [WIDTH_C_LEN-1:0]             clause_len_o;

  // Clause array read side
  logic [NUM_CLAUSES-1:0]             rd_o;
  logic [CW-1:0]                      clause_i;
  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] clause_len_i;

  // Unload stream
  logic                               unload_valid_o;
  logic                               unload_ready_i;
  logic [CW-1:0]                      unload_clause_o;
  logic [WIDTH_C_LEN-1:0]             unload_len_o;
  logic                               unload_last_o;

  // Status
  logic                               busy_o;
  logic                               done_o;
  logic [CNT_W-1:0]                   num_loaded_o;

  // Controller side
  modport slave (
    input  load_start_i, unload_start_i,
    input  load_valid_i, load_clause_i, load_len_i, load_last_i,
    output load_ready_o,
    output wr_o, clause_o, clause_len_o,
    output rd_o,
    input  clause_i, clause_len_i,
    output unload_valid_o, unload_clause_o, unload_len_o, unload_last_o,
    input  unload_ready_i,
    output busy_o, done_o, num_loaded_o
  );

  // Environment side (stream source/sink and clause array)
  modport master (
    output load_start_i, unload_start_i,
    output load_valid_i, load_clause_i, load_len_i, load_last_i,
    input  load_ready_o,
    input  wr_o, clause_o, clause_len_o,
    input  rd_o,
    output clause_i, clause_len_i,
    input  unload_valid_o, unload_clause_o, unload_len_o, unload_last_o,
    output unload_ready_i,
    input  busy_o, done_o, num_loaded_o
  );
endinterface

// File: rtl/clause_load_ctrl.sv
// Clause load/unload controller: streams clauses into a one-hot addressed
// clause array (zero-filling unused slots), and streams non-empty clauses back
// out with valid/ready backpressure.
module clause_load_ctrl #(
  parameter int NUM_VARS    = 8,
  parameter int NUM_CLAUSES = 8,
  parameter int WIDTH_C_LEN = 4
) (
  input logic              clk,
  input logic              rst,
  clause_load_ctrl_if.slave bus
);
  localparam int CW    = NUM_VARS * 2;
  localparam int PTR_W = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
  localparam int CNT_W = $clog2(NUM_CLAUSES + 1);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_CLAUSES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, UNLOAD, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [PTR_W-1:0]       ptr_reg;
  logic [CNT_W-1:0]       num_loaded_reg;
  logic                   scan_done_reg;

  logic [NUM_CLAUSES-1:0] wr_reg;
  logic [CW-1:0]          clause_reg;
  logic [WIDTH_C_LEN-1:0] clause_len_reg;

  logic                   uvalid_reg;
  logic [CW-1:0]          uclause_reg;
  logic [WIDTH_C_LEN-1:0] ulen_reg;
  logic                   ulast_reg;

  // Per-slot decode of the pointer and of the array length fields
  logic [NUM_CLAUSES-1:0] slot_sel;
  logic [NUM_CLAUSES-1:0] after_mask;
  logic [NUM_CLAUSES-1:0] len_nz;
  logic [WIDTH_C_LEN-1:0] len_field [NUM_CLAUSES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLAUSES; gi++) begin : g_slot
      assign len_field[gi]  = bus.clause_len_i[gi*WIDTH_C_LEN +: WIDTH_C_LEN];
      assign len_nz[gi]     = |len_field[gi];
      assign slot_sel[gi]   = (ptr_reg == PTR_W'(gi));
      assign after_mask[gi] = (PTR_W'(gi) > ptr_reg);
    end
  endgenerate

  logic                   at_last;
  logic                   cur_nz;
  logic                   more_after;
  logic [WIDTH_C_LEN-1:0] cur_len;
  logic                   out_free;

  assign at_last    = (ptr_reg == LAST_SLOT);
  assign cur_nz     = |(len_nz & slot_sel);
  // Lengths of all slots are visible at once, so "last beat" is known up front
  assign more_after = |(len_nz & after_mask);
  assign cur_len    = len_field[ptr_reg];
  assign out_free   = !uvalid_reg || bus.unload_ready_i;

  logic load_ready;
  logic accept;
  logic clear_wr;
  logic scan_step;

  // Next-state and per-cycle strobes
  always_comb begin
    state_next = state_reg;
    load_ready = 1'b0;
    accept     = 1'b0;
    clear_wr   = 1'b0;
    scan_step  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.load_start_i)        state_next = LOAD;
        else if (bus.unload_start_i) state_next = UNLOAD;
      end
      LOAD: begin
        load_ready = 1'b1;
        accept     = bus.load_valid_i;
        if (accept && (bus.load_last_i || at_last))
          state_next = at_last ? DONE : CLEAR;
      end
      CLEAR: begin
        clear_wr = 1'b1;
        if (at_last) state_next = DONE;
      end
      UNLOAD: begin
        // Scan only advances when the output register can take a new beat
        scan_step = !scan_done_reg && out_free;
        if (scan_done_reg && out_free) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Pointer, counters, array write pulse and unload output register
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_reg        <= '0;
      num_loaded_reg <= '0;
      scan_done_reg  <= 1'b0;
      wr_reg         <= '0;
      clause_reg     <= '0;
      clause_len_reg <= '0;
      uvalid_reg     <= 1'b0;
      uclause_reg    <= '0;
      ulen_reg       <= '0;
      ulast_reg      <= 1'b0;
    end else begin
      wr_reg         <= '0;
      clause_reg     <= '0;
      clause_len_reg <= '0;

      if (state_reg == IDLE) begin
        ptr_reg       <= '0;
        scan_done_reg <= 1'b0;
        if (bus.load_start_i) num_loaded_reg <= '0;
      end

      if (accept) begin
        wr_reg         <= slot_sel;
        clause_reg     <= bus.load_clause_i;
        clause_len_reg <= bus.load_len_i;
        num_loaded_reg <= num_loaded_reg + CNT_W'(1);
        if (!at_last) ptr_reg <= ptr_reg + PTR_W'(1);
      end

      if (clear_wr) begin
        wr_reg <= slot_sel;
        if (!at_last) ptr_reg <= ptr_reg + PTR_W'(1);
      end

      if (state_reg == UNLOAD) begin
        if (uvalid_reg && bus.unload_ready_i) begin
          uvalid_reg  <= 1'b0;
          uclause_reg <= '0;
          ulen_reg    <= '0;
          ulast_reg   <= 1'b0;
        end
        if (scan_step) begin
          if (cur_nz) begin
            uvalid_reg  <= 1'b1;
            uclause_reg <= bus.clause_i;
            ulen_reg    <= cur_len;
            ulast_reg   <= !more_after;
          end
          if (at_last) scan_done_reg <= 1'b1;
          else         ptr_reg       <= ptr_reg + PTR_W'(1);
        end
      end
    end
  end

  assign bus.load_ready_o    = load_ready;
  assign bus.wr_o            = wr_reg;
  assign bus.clause_o        = clause_reg;
  assign bus.clause_len_o    = clause_len_reg;
  assign bus.rd_o            = (state_reg == UNLOAD && !scan_done_reg) ? slot_sel : '0;
  assign bus.unload_valid_o  = uvalid_reg;
  assign bus.unload_clause_o = uclause_reg;
  assign bus.unload_len_o    = ulen_reg;
  assign bus.unload_last_o   = ulast_reg;
  assign bus.busy_o          = (state_reg != IDLE);
  assign bus.done_o          = (state_reg == DONE);
  assign bus.num_loaded_o    = num_loaded_reg;
endmodule
